isqrt_responder: RTL

Sequential integer square-root engine answering the start/valid request protocol used by the lab top-level wrappers. A wrapper pulses `start` with an operand on `a`. The block computes floor(sqrt(a)) and the remainder, one result bit per cycle, using the digit-by-digit (binary restoring) method. It then raises `valid` and holds the result until the next request. This is the responder end of the handshake that the stimulus wrappers drive.

---
 rtl/isqrt_pkg.sv | 15 +
 rtl/isqrt_step.sv | 31 +++
 rtl/isqrt_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and width constants for the
// sequential integer square-root responder.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } isqrt_state_t;

  localparam int ISQRT_W = 8;
  localparam int ROOT_W  = ISQRT_W / 2;
  localparam int REM_W   = ROOT_W + 1;

endpackage

// File: rtl/isqrt_step.sv
// One digit-by-digit restoring square-root iteration:
// brings in two operand bits and resolves one root bit.
module isqrt_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH/2+1:0] wrem_i,
  input  logic [WIDTH/2-1:0] wroot_i,
  input  logic [1:0]         bits_i,
  output logic [WIDTH/2+1:0] wrem_o,
  output logic [WIDTH/2-1:0] wroot_o
);

  localparam int RW = WIDTH / 2;
  localparam int WR = RW + 2;

  logic [WR+1:0] shifted;
  logic [WR+1:0] sub;
  logic [WR-1:0] diff;
  logic          ge;

  always_comb begin
    shifted = {wrem_i, bits_i};
    sub     = {2'b00, wroot_i, 2'b01};
    // wide compare stands in for the trial sign bit
    ge      = (shifted >= sub);
    diff    = shifted[WR-1:0] - sub[WR-1:0];
    wrem_o  = ge ? diff : shifted[WR-1:0];
    wroot_o = (wroot_i << 1) | RW'(ge);
  end

endmodule

// File: rtl/isqrt_responder.sv
// Start/valid responder computing floor(sqrt(a)) and
// remainder, one root bit per cycle.
module isqrt_responder
  import isqrt_pkg::*;
#(
  parameter int WIDTH = ISQRT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  output logic               valid,
  output logic               busy,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);

  localparam int RW    = WIDTH / 2;
  localparam int WR    = RW + 2;
  localparam int CNT_W = $clog2(RW) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RW - 1);

  isqrt_state_t     state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WR-1:0]    wrem_q, wrem_d;
  logic [RW-1:0]    wroot_q, wroot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    root_q, root_d;
  logic [RW:0]      rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WR-1:0]    step_rem;
  logic [RW-1:0]    step_root;

  isqrt_step #(.WIDTH(WIDTH)) u_step (
    .wrem_i  (wrem_q),
    .wroot_i (wroot_q),
    .bits_i  (opnd_q[WIDTH-1:WIDTH-2]),
    .wrem_o  (step_rem),
    .wroot_o (step_root)
  );

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    wrem_d  = wrem_q;
    wroot_d = wroot_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    // a new request always wins, even mid-iteration
    if (start) begin
      state_d = CALC;
      opnd_d  = a;
      wrem_d  = '0;
      wroot_d = '0;
      cnt_d   = CNT_LOAD;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        CALC: begin
          wrem_d  = step_rem;
          wroot_d = step_root;
          opnd_d  = opnd_q << 2;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = DONE;
            cnt_d   = cnt_q;
            root_d  = step_root;
            rem_d   = step_rem[RW:0];
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      wrem_q  <= '0;
      wroot_q <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      wrem_q  <= wrem_d;
      wroot_q <= wroot_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign valid = valid_q;
  assign busy  = busy_q;
  assign root  = root_q;
  assign rem   = rem_q;

endmodule
